mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported data memory stage between two requesters: port 0 = CPU load/store, port 1 = loader/debug.
//  Round-robin arbitration, one transaction in flight, and a range/size check before any memory access.
//  Sits between the requesters and the mem stage and owns the mem stage's memRW/dataSec/addr/dataW inputs.
// PARAMETERS
//  N          20   highest valid byte index of the data memory (the memory holds N+1 bytes)
//  ERR_CNT_W  16   width of the saturating error counter
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst_n          in   1      asynchronous reset, active-low
//  req_valid_i    in   [1:0]  per-port request valid
//  req_ready_o    out  [1:0]  per-port request accept; one-hot or zero
//  req_rw_i       in   2x1    1 = read, 0 = write (mem stage memRW encoding)
//  req_sec_i      in   2x2    size: 00 byte, 01 half, 10 word, 11 illegal
//  req_addr_i     in   2x32   byte address; the first byte is the MSB of the data (big-endian)
//  req_wdata_i    in   2x32   write data; byte/half taken from the low bits
//  rsp_valid_o    out  [1:0]  per-port response strobe, one cycle wide
//  rsp_rdata_o    out  32     read data, shared by both ports; qualified by rsp_valid_o
//  rsp_err_o      out  1      response is an error; qualified by rsp_valid_o
//  mem_rw_o       out  1      to mem stage memRW
//  mem_sec_o      out  2      to mem stage dataSec
//  mem_addr_o     out  32     to mem stage addr
//  mem_wdata_o    out  32     to mem stage dataW
//  mem_rdata_i    in   32     mem stage data_o; registered, valid the cycle after ACCESS
//  err_cnt_o      out  ERR_CNT_W  count of rejected requests, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; req_ready_o=0; rsp_valid_o=0; rsp_rdata_o=32'hFFFFFFFF; rsp_err_o=0; err_cnt_o=0.
//   - mem_rw_o=1, mem_sec_o=00, mem_addr_o=0, mem_wdata_o=0.
//   - RR pointer = "port 1 granted last", so port 0 wins the first tie.
//  Memory safety: mem_rw_o=1 (read) in every state except ACCESS of a write. The mem stage writes whenever memRW=0,
//   so a spurious 0 corrupts memory. mem_* outputs are registered; no glitches.
//  Handshake: transfer when req_valid_i[p] & req_ready_o[p]. A requester holds its fields stable while valid & !ready.
//   ready is asserted only in IDLE, for the granted port only, for one cycle.
//  Arbitration (IDLE): one port valid -> grant it. Both valid -> grant the port not granted last.
//   The pointer updates on every accepted transfer.
//  Range check on the accepted request: bytes = 1/2/4 for sec 00/01/10.
//   err = (sec==11) | ({1'b0,addr} + bytes - 1 > N), computed at 33 bits so addr near 2^32 cannot wrap.
//  FSM:
//   IDLE   -> ACCESS  on accept, err=0; latch port, rw, sec, addr, wdata; drive mem_*
//   IDLE   -> ERRRSP  on accept, err=1; the memory is never driven
//   ACCESS -> RESP    always; exactly one cycle with mem_* driven
//   RESP   -> IDLE    rsp_valid_o[port]=1; rsp_err_o=0; rsp_rdata_o = mem_rdata_i for reads, 32'hFFFFFFFF for writes
//   ERRRSP -> IDLE    rsp_valid_o[port]=1; rsp_err_o=1; rsp_rdata_o=32'hFFFFFFFF; err_cnt_o += 1, saturating at all-ones
//  Latency: accept at cycle t -> response at t+2 (legal) or t+1 (error).
//   Next accept no earlier than t+3 (legal) or t+2 (error). Max throughput is 1 transaction per 3 cycles.
//  Reset mid-transaction: the transaction is aborted and no response is issued.
//   mem_rw_o returns to 1 asynchronously, so a write in ACCESS may or may not have committed.
//  Dropping valid before ready: legal; nothing is latched. Re-raising valid re-enters arbitration.
// STRUCTURE
//  mem_pkg (shared package):
//   - typedef enum logic [1:0] mem_sec_e {SEC_BYTE=2'b00, SEC_HALF=2'b01, SEC_WORD=2'b10}
//   - localparams MEM_READ=1'b1, MEM_WRITE=1'b0
//   - function sec_bytes(mem_sec_e) -> 3-bit byte count
//  FSM state enum: local to this module.
//  Sub-module rr_arbiter2: 2-way round-robin with pointer register.
//   Ports: clk, rst_n, req[1:0], advance, gnt[1:0].
// TESTING
//  1. Port 0 word write addr 4 data 32'hDEADBEEF, then word read addr 4
//     -> rsp rdata 32'hDEADBEEF, err=0; read response 2 cycles after accept.
//  2. Both ports valid every cycle for 6 transactions -> grants alternate 0,1,0,1,0,1;
//     no response is lost or misrouted.
//  3. Word read at addr N-2 (=18) -> err=1, rdata FFFFFFFF, response at t+1,
//     mem_rw_o stays 1 throughout, err_cnt_o=1.
//  4. sec=11, and addr 32'hFFFFFFFE byte write -> both rejected, memory unchanged
//     (read back shows the prior value), err_cnt_o increments twice.
//  5. Half write addr N-1 data 16'hA55A -> legal; half read -> rdata[31:16]=16'hA55A.
//  6. rst_n pulled low in ACCESS of a write -> mem_rw_o=1 immediately, no rsp_valid_o,
//     FSM IDLE after release, port 0 wins the next tie.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access definitions: transfer size encoding, memRW polarity
// and the size-to-byte-count helper used by the range check.
package mem_pkg;

  typedef enum logic [1:0] {
    SEC_BYTE = 2'b00,
    SEC_HALF = 2'b01,
    SEC_WORD = 2'b10
  } mem_sec_e;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  function automatic logic [2:0] sec_bytes(input mem_sec_e sec);
    case (sec)
      SEC_BYTE: sec_bytes = 3'd1;
      SEC_HALF: sec_bytes = 3'd2;
      SEC_WORD: sec_bytes = 3'd4;
      default:  sec_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer records which port won last and
// only moves when the caller reports that the grant was actually taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // Grant selection: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer next-state.
  always_comb begin
    if (advance) begin
      last_d = gnt[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; resets to "port 1 granted last" so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory stage between the CPU (port 0) and the
// loader/debug port (port 1); range-checks each request before touching memory.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int N         = 20,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0]           req_rw_i,
  input  logic [1:0][1:0]      req_sec_i,
  input  logic [1:0][31:0]     req_addr_i,
  input  logic [1:0][31:0]     req_wdata_i,
  output logic [1:0]           rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 mem_rw_o,
  output logic [1:0]           mem_sec_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10,
    ST_ERRRSP = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic                  run_q;
  logic [1:0]            gnt_s;
  logic                  accept_s;
  logic                  sel_port_s;
  logic                  sel_rw_s;
  logic [1:0]            sel_sec_s;
  logic [31:0]           sel_addr_s;
  logic [31:0]           sel_wdata_s;
  logic [2:0]            bytes_s;
  logic [32:0]           end_addr_s;
  logic                  err_s;
  logic                  port_q, port_d;
  logic                  rw_q, rw_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [1:0]            mem_sec_q, mem_sec_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid_i),
    .advance (accept_s),
    .gnt     (gnt_s)
  );

  // Granted request and its range check; the end address is 33 bits so it cannot wrap.
  always_comb begin
    sel_port_s  = gnt_s[1];
    sel_rw_s    = req_rw_i[sel_port_s];
    sel_sec_s   = req_sec_i[sel_port_s];
    sel_addr_s  = req_addr_i[sel_port_s];
    sel_wdata_s = req_wdata_i[sel_port_s];
    bytes_s     = sec_bytes(mem_sec_e'(sel_sec_s));
    end_addr_s  = {1'b0, sel_addr_s} + {30'd0, bytes_s} - 33'd1;
    err_s       = (sel_sec_s == 2'b11) || (end_addr_s > 33'(N));
    accept_s    = |(req_valid_i & req_ready_o);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = err_s ? ST_ERRRSP : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      ST_ERRRSP: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake and response outputs; ready is held off for one cycle after reset release.
  always_comb begin
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = 32'hFFFF_FFFF;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = run_q ? gnt_s : 2'b00;
      end
      ST_RESP: begin
        rsp_valid_o = port_q ? 2'b10 : 2'b01;
        rsp_rdata_o = (rw_q == MEM_READ) ? mem_rdata_i : 32'hFFFF_FFFF;
      end
      ST_ERRRSP: begin
        rsp_valid_o = port_q ? 2'b10 : 2'b01;
        rsp_err_o   = 1'b1;
      end
      default: begin
        req_ready_o = 2'b00;
      end
    endcase
  end

  // Transaction latch and mem-stage drive; memRW is a write only during ACCESS of a legal write.
  always_comb begin
    port_d      = port_q;
    rw_d        = rw_q;
    mem_rw_d    = MEM_READ;
    mem_sec_d   = mem_sec_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if ((state_q == ST_IDLE) && accept_s) begin
      port_d = sel_port_s;
      if (!err_s) begin
        rw_d        = sel_rw_s;
        mem_rw_d    = sel_rw_s;
        mem_sec_d   = sel_sec_s;
        mem_addr_d  = sel_addr_s;
        mem_wdata_d = sel_wdata_s;
      end else begin
        rw_d = MEM_READ;
      end
    end else begin
      port_d = port_q;
    end
  end

  // Saturating count of rejected requests.
  always_comb begin
    if ((state_q == ST_ERRRSP) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1'b1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      port_q      <= 1'b0;
      rw_q        <= MEM_READ;
      mem_rw_q    <= MEM_READ;
      mem_sec_q   <= 2'b00;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      err_cnt_q   <= {ERR_CNT_W{1'b0}};
    end else begin
      run_q       <= 1'b1;
      port_q      <= port_d;
      rw_q        <= rw_d;
      mem_rw_q    <= mem_rw_d;
      mem_sec_q   <= mem_sec_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mem_rw_o    = mem_rw_q;
  assign mem_sec_o   = mem_sec_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian byte memory standing in
// for the mem stage (registered read data, write whenever memRW is 0).
module tb_mem_port_arbiter;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready_o;
  logic [1:0]        req_rw;
  logic [1:0][1:0]   req_sec;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              mem_rw_o;
  logic [1:0]        mem_sec_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata;
  logic [15:0]       err_cnt_o;

  int checks = 0;
  int errors = 0;
  int rw_low_cnt = 0;
  int nb;
  logic [7:0] mem [0:20] = '{default: 8'h00};

  mem_port_arbiter #(.N(20), .ERR_CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_rw_i    (req_rw),
    .req_sec_i   (req_sec),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .mem_rw_o    (mem_rw_o),
    .mem_sec_o   (mem_sec_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata),
    .err_cnt_o   (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    rd = (a <= 32'd20) ? mem[a[4:0]] : 8'h00;
  endfunction

  // Mem stage model: data_o registered every cycle, byte writes MSB-first when memRW is 0.
  always @(posedge clk) begin
    mem_rdata <= {rd(mem_addr_o), rd(mem_addr_o + 32'd1), rd(mem_addr_o + 32'd2), rd(mem_addr_o + 32'd3)};
    if (mem_rw_o == 1'b0) begin
      rw_low_cnt <= rw_low_cnt + 1;
      nb = (mem_sec_o == 2'b00) ? 1 : (mem_sec_o == 2'b01) ? 2 : 4;
      for (int i = 0; i < 4; i++) begin
        if ((i < nb) && ((mem_addr_o + 32'(i)) <= 32'd20)) begin
          mem[5'(mem_addr_o + 32'(i))] <= 8'(mem_wdata_o >> (8 * (nb - 1 - i)));
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on port p; returns the response seen and its latency in cycles after accept.
  task automatic txn(input int p, input logic rw, input logic [1:0] sec, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                     output int lat, output logic [1:0] vld);
    int n;
    req_rw[p]    = rw;
    req_sec[p]   = sec;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
    req_valid[p] = 1'b1;
    #1;
    n = 0;
    while (!req_ready_o[p] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready timeout", 32'(n < 10), 32'd1);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid_o == 2'b00 && lat < 10);
    vld   = rsp_valid_o;
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;
  logic [1:0]  vld;
  logic [1:0]  gq [6];
  logic [1:0]  rq [6];
  logic [31:0] dq [6];
  int          g, r, cyc, snap;

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_rw    = 2'b11;
    req_sec   = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst ready", 32'(req_ready_o), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst rdata", rsp_rdata_o, 32'hFFFF_FFFF);
    check("rst err", 32'(rsp_err_o), 32'd0);
    check("rst err_cnt", 32'(err_cnt_o), 32'd0);
    check("rst mem_rw", 32'(mem_rw_o), 32'd1);
    check("rst mem_sec", 32'(mem_sec_o), 32'd0);
    check("rst mem_addr", mem_addr_o, 32'd0);
    check("rst mem_wdata", mem_wdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: word write then read back on port 0.
    txn(0, 1'b0, 2'b10, 32'd4, 32'hDEAD_BEEF, rdata, err, lat, vld);
    check("t1 wr vld", 32'(vld), 32'd1);
    check("t1 wr lat", 32'(lat), 32'd2);
    check("t1 wr rdata", rdata, 32'hFFFF_FFFF);
    txn(0, 1'b1, 2'b10, 32'd4, 32'd0, rdata, err, lat, vld);
    check("t1 rd vld", 32'(vld), 32'd1);
    check("t1 rd lat", 32'(lat), 32'd2);
    check("t1 rd rdata", rdata, 32'hDEAD_BEEF);
    check("t1 rd err", 32'(err), 32'd0);
    txn(1, 1'b0, 2'b10, 32'd8, 32'hCAFE_F00D, rdata, err, lat, vld);
    check("p1 wr vld", 32'(vld), 32'd2);

    // Test 2: both ports valid every cycle; grants alternate starting at port 0.
    req_rw    = 2'b11;
    req_sec   = {2'b10, 2'b10};
    req_addr  = {32'd8, 32'd4};
    req_valid = 2'b11;
    g = 0; r = 0; cyc = 0;
    while ((g < 6 || r < 6) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req_ready_o != 2'b00 && g < 6) begin
        gq[g] = req_ready_o;
        g++;
      end
      if (rsp_valid_o != 2'b00 && r < 6) begin
        rq[r] = rsp_valid_o;
        dq[r] = rsp_rdata_o;
        r++;
      end
    end
    req_valid = 2'b00;
    check("t2 complete", 32'(cyc < 60), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("t2 grant", 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("t2 rsp port", 32'(rq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("t2 rsp data", dq[i], (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
    end

    // Test 3: word read at 18 overruns the 21-byte memory.
    snap = rw_low_cnt;
    txn(0, 1'b1, 2'b10, 32'd18, 32'd0, rdata, err, lat, vld);
    check("t3 vld", 32'(vld), 32'd1);
    check("t3 err", 32'(err), 32'd1);
    check("t3 rdata", rdata, 32'hFFFF_FFFF);
    check("t3 lat", 32'(lat), 32'd1);
    @(negedge clk);
    check("t3 err_cnt", 32'(err_cnt_o), 32'd1);
    check("t3 no write", 32'(rw_low_cnt), 32'(snap));

    // Test 4: illegal size write and a wrapping address write are both rejected.
    txn(0, 1'b0, 2'b11, 32'd4, 32'd0, rdata, err, lat, vld);
    check("t4a err", 32'(err), 32'd1);
    check("t4a lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'h55, rdata, err, lat, vld);
    check("t4b err", 32'(err), 32'd1);
    check("t4b vld", 32'(vld), 32'd2);
    @(negedge clk);
    check("t4 err_cnt", 32'(err_cnt_o), 32'd3);
    check("t4 no write", 32'(rw_low_cnt), 32'(snap));
    txn(0, 1'b1, 2'b10, 32'd4, 32'd0, rdata, err, lat, vld);
    check("t4 readback", rdata, 32'hDEAD_BEEF);

    // Test 5: half write at the last legal halfword.
    txn(1, 1'b0, 2'b01, 32'd19, 32'h0000_A55A, rdata, err, lat, vld);
    check("t5 wr err", 32'(err), 32'd0);
    check("t5 wr lat", 32'(lat), 32'd2);
    txn(1, 1'b1, 2'b01, 32'd19, 32'd0, rdata, err, lat, vld);
    check("t5 rd half", 32'(rdata[31:16]), 32'h0000_A55A);
    check("t5 rd err", 32'(err), 32'd0);

    // Test 6: reset during ACCESS of a write.
    req_rw[0] = 1'b0; req_sec[0] = 2'b10; req_addr[0] = 32'd0; req_wdata[0] = 32'h1122_3344;
    req_valid[0] = 1'b1;
    #1;
    cyc = 0;
    while (!req_ready_o[0] && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    check("t6 access write", 32'(mem_rw_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async mem_rw", 32'(mem_rw_o), 32'd1);
    check("t6 no rsp in rst", 32'(rsp_valid_o), 32'd0);
    g = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00) g++;
    end
    check("t6 no rsp", 32'(g), 32'd0);
    check("t6 not committed", 32'(mem[0]), 32'd0);
    check("t6 err_cnt cleared", 32'(err_cnt_o), 32'd0);
    rst_n = 1'b1;
    req_rw    = 2'b11;
    req_sec   = {2'b10, 2'b10};
    req_addr  = {32'd8, 32'd4};
    req_valid = 2'b11;
    #1;
    cyc = 0; g = 0;
    while (req_ready_o == 2'b00 && cyc < 10) begin
      if (rsp_valid_o != 2'b00) g++;
      @(negedge clk);
      cyc++;
    end
    check("t6 no stray rsp", 32'(g), 32'd0);
    check("t6 tie to port0", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid_o == 2'b00 && lat < 10);
    check("t6 rsp port", 32'(rsp_valid_o), 32'd1);
    check("t6 rsp data", rsp_rdata_o, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
